mpmc10_rd_line_assembler: RTL and testbench
===========================================

Name: mpmc10_rd_line_assembler

Overview:
- Companion stage to the controller's read address generator.
- Counts read commands accepted by the memory interface and produces the strip counter that the address generator compares against num_strips.
- Collects the returned 128-bit read strips into one cache line and presents that line to the port-side read cache with a valid/ack handshake.
- Sits between the DRAM app interface (rdy, rd_data_valid, rd_data) and the read-cache fill logic, driven by the controller state.

Parameters:
- WID, 128: strip (app data) width in bits.
- NSTRIPS, 4: strips per assembled line; line width is NSTRIPS*WID.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- state  input  mpmc10_state_t  controller state (PRESET2, READ_DATA1 used).
- rdy  input  1  app interface command accepted.
- num_strips  input  6  index of the last strip in the burst (strips 0..num_strips).
- rd_data_valid  input  1  app read data beat valid.
- rd_data  input  WID  app read data beat.
- line_ack  input  1  consumer has taken the line.
- req_strip_cnt  output  6  read commands accepted this burst.
- resp_strip_cnt  output  6  index of the next strip expected.
- line  output  NSTRIPS*WID  assembled line.
- line_valid  output  1  line complete and held.
- busy  output  1  FSM not IDLE.
- overflow  output  1  sticky; an unexpected beat was dropped.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - req_strip_cnt = 0, resp_strip_cnt = 0.
  - line = 0, line_valid = 0, overflow = 0, busy = 0.
  - FSM = IDLE; internal nstr_q = 0.
- FSM states: IDLE, COLLECT, HOLD. busy = (FSM != IDLE), registered alongside the FSM.
- PRESET2 (highest priority after rst, any FSM state, including HOLD):
  - nstr_q <= num_strips.
  - req_strip_cnt <= 0, resp_strip_cnt <= 0.
  - line_valid <= 0, overflow <= 0, FSM <= COLLECT.
  - line contents are retained, not cleared.
  - Beats arriving in the same cycle are dropped and do not set overflow.
- Request counting:
  - When state==READ_DATA1 && rdy && req_strip_cnt != nstr_q, then req_strip_cnt <= req_strip_cnt + 1.
  - The counter saturates at nstr_q.
  - This is the same condition under which the address generator advances, so addr = base + 16*req_strip_cnt holds throughout the burst.
  - Request counting is independent of the FSM.
- Response collection (FSM == COLLECT, rd_data_valid = 1):
  - If resp_strip_cnt < NSTRIPS, write line[resp_strip_cnt*WID +: WID] <= rd_data. Beats with a higher index are counted but not stored.
  - If resp_strip_cnt == nstr_q: line_valid <= 1, FSM <= HOLD; resp_strip_cnt holds.
  - Otherwise: resp_strip_cnt <= resp_strip_cnt + 1.
- Latency: line_valid rises the cycle after the final beat is sampled, and line is stable in that same cycle.
- HOLD:
  - line and line_valid are held until line_ack.
  - On line_ack: line_valid <= 0, FSM <= IDLE.
  - line_ack outside HOLD is ignored.
- Dropped beats: rd_data_valid in IDLE or HOLD (other than a PRESET2 cycle) is dropped, and overflow <= 1. overflow is cleared only by rst or PRESET2.
- Simultaneous events:
  - rdy increment and beat capture in the same cycle both take effect.
  - line_ack together with PRESET2: PRESET2 wins (FSM goes to COLLECT).
- No check that responses never lead requests; the in-order app interface guarantees it.
- num_strips is sampled only at PRESET2; later changes do not affect the burst in progress.
- Counter arithmetic is 6-bit and never wraps, because saturation or the HOLD transition occurs first.

Test Plan:
- Basic 4-strip read: PRESET2 with num_strips=3; 4 rdy pulses in READ_DATA1; beats A0..A3 -> req_strip_cnt steps 0,1,2,3 then stays 3; line = {A3,A2,A1,A0}; line_valid=1 the cycle after A3; line_ack -> line_valid=0 and busy=0 next cycle.
- rdy saturation: num_strips=1 with 5 rdy pulses -> req_strip_cnt ends at 1; it never reaches 2.
- Single strip: num_strips=0, one beat 0xDEAD... -> line[127:0] = beat, line_valid next cycle, resp_strip_cnt=0.
- Stray beat: rd_data_valid while in HOLD -> overflow=1 and line unchanged; next PRESET2 -> overflow=0.
- Abort: PRESET2 while in HOLD with line_ack high in the same cycle -> FSM=COLLECT, line_valid=0, both counters 0.
- Oversized burst: NSTRIPS=4, num_strips=5 with 6 beats -> only beats 0..3 stored; line_valid after the 6th beat; resp_strip_cnt=5.

Source files
------------

// File: rtl/mpmc10_rd_line_assembler.sv
// Read-side companion to the mpmc10 address generator: counts accepted read
// commands and assembles the returned strips into one cache line for the read cache.
package mpmc10_pkg;
   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      PRESET1    = 4'd1,
      PRESET2    = 4'd2,
      PRESET3    = 4'd3,
      READ_DATA0 = 4'd4,
      READ_DATA1 = 4'd5,
      READ_DATA2 = 4'd6,
      WRITE_DATA = 4'd7,
      WAIT_NACK  = 4'd8
   } mpmc10_state_t;
endpackage

module mpmc10_rd_line_assembler
   import mpmc10_pkg::*;
#(
   parameter int WID     = 128,
   parameter int NSTRIPS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  mpmc10_state_t          state,
   input  logic                   rdy,
   input  logic [5:0]             num_strips,
   input  logic                   rd_data_valid,
   input  logic [WID-1:0]         rd_data,
   input  logic                   line_ack,
   output logic [5:0]             req_strip_cnt,
   output logic [5:0]             resp_strip_cnt,
   output logic [NSTRIPS*WID-1:0] line,
   output logic                   line_valid,
   output logic                   busy,
   output logic                   overflow
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_HOLD    = 2'd2
   } fsm_t;

   fsm_t                   fsm_q;
   logic [5:0]             nstr_q;
   logic [5:0]             req_q;
   logic [5:0]             resp_q;
   logic [NSTRIPS*WID-1:0] line_q;
   logic                   valid_q;
   logic                   busy_q;
   logic                   ovf_q;

   // Burst FSM, request/response counters and line storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q   <= S_IDLE;
         nstr_q  <= 6'd0;
         req_q   <= 6'd0;
         resp_q  <= 6'd0;
         line_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (state == PRESET2) begin
         // New burst: line contents are kept, beats this cycle are discarded.
         fsm_q   <= S_COLLECT;
         nstr_q  <= num_strips;
         req_q   <= 6'd0;
         resp_q  <= 6'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         if (state == READ_DATA1 && rdy && req_q != nstr_q) begin
            req_q <= req_q + 6'd1;
         end
         case (fsm_q)
            S_COLLECT: begin
               if (rd_data_valid) begin
                  for (int i = 0; i < NSTRIPS; i++) begin
                     if (resp_q == 6'(i)) begin
                        line_q[i*WID +: WID] <= rd_data;
                     end
                  end
                  if (resp_q == nstr_q) begin
                     valid_q <= 1'b1;
                     fsm_q   <= S_HOLD;
                  end else begin
                     resp_q <= resp_q + 6'd1;
                  end
               end
            end
            S_HOLD: begin
               if (rd_data_valid) begin
                  ovf_q <= 1'b1;
               end
               if (line_ack) begin
                  valid_q <= 1'b0;
                  fsm_q   <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            S_IDLE: begin
               if (rd_data_valid) begin
                  ovf_q <= 1'b1;
               end
            end
            default: begin
               fsm_q  <= S_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_strip_cnt  = req_q;
   assign resp_strip_cnt = resp_q;
   assign line           = line_q;
   assign line_valid     = valid_q;
   assign busy           = busy_q;
   assign overflow       = ovf_q;

endmodule

// File: tb/tb_mpmc10_rd_line_assembler.sv
// Directed plus random stimulus for mpmc10_rd_line_assembler, checked against a
// burst-level reference model (beat/command counts and a strip array).
module tb_mpmc10_rd_line_assembler;
   import mpmc10_pkg::*;

   localparam int WID     = 128;
   localparam int NSTRIPS = 4;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   mpmc10_state_t          state = ST_IDLE;
   logic                   rdy = 1'b0;
   logic [5:0]             num_strips = 6'd0;
   logic                   rd_data_valid = 1'b0;
   logic [WID-1:0]         rd_data = '0;
   logic                   line_ack = 1'b0;
   logic [5:0]             req_strip_cnt;
   logic [5:0]             resp_strip_cnt;
   logic [NSTRIPS*WID-1:0] line;
   logic                   line_valid;
   logic                   busy;
   logic                   overflow;

   int total = 0;
   int bad   = 0;

   // Reference model: burst-level bookkeeping only.
   int             m_phase;     // 0 idle, 1 collecting, 2 holding
   int             m_nstr;
   int             m_rdys;
   int             m_beats;
   bit             m_ovf;
   logic [WID-1:0] m_strip [NSTRIPS];

   mpmc10_rd_line_assembler #(.WID(WID), .NSTRIPS(NSTRIPS)) dut (
      .clk(clk), .rst(rst), .state(state), .rdy(rdy), .num_strips(num_strips),
      .rd_data_valid(rd_data_valid), .rd_data(rd_data), .line_ack(line_ack),
      .req_strip_cnt(req_strip_cnt), .resp_strip_cnt(resp_strip_cnt), .line(line),
      .line_valid(line_valid), .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic chk(input string tag, input logic [NSTRIPS*WID-1:0] obs,
                      input logic [NSTRIPS*WID-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      logic [NSTRIPS*WID-1:0] exp_line;
      for (int i = 0; i < NSTRIPS; i++) exp_line[i*WID +: WID] = m_strip[i];
      chk({ctx, ".req"},   NSTRIPS*WID'(req_strip_cnt),  NSTRIPS*WID'(imin(m_rdys, m_nstr)));
      chk({ctx, ".resp"},  NSTRIPS*WID'(resp_strip_cnt), NSTRIPS*WID'(imin(m_beats, m_nstr)));
      chk({ctx, ".valid"}, NSTRIPS*WID'(line_valid),     NSTRIPS*WID'(m_phase == 2));
      chk({ctx, ".busy"},  NSTRIPS*WID'(busy),           NSTRIPS*WID'(m_phase != 0));
      chk({ctx, ".ovf"},   NSTRIPS*WID'(overflow),       NSTRIPS*WID'(m_ovf));
      chk({ctx, ".line"},  line, exp_line);
   endtask

   // Apply one cycle of inputs, advance the model, then compare everything.
   task automatic step(input string ctx, input mpmc10_state_t st, input bit r,
                       input int ns, input bit dv, input logic [WID-1:0] d, input bit ack);
      int old;
      state = st; rdy = r; num_strips = 6'(ns);
      rd_data_valid = dv; rd_data = d; line_ack = ack;
      @(posedge clk);
      #1;
      old = m_phase;
      if (rst) begin
         m_phase = 0; m_nstr = 0; m_rdys = 0; m_beats = 0; m_ovf = 1'b0;
         for (int i = 0; i < NSTRIPS; i++) m_strip[i] = '0;
      end else if (st == PRESET2) begin
         m_phase = 1; m_nstr = ns; m_rdys = 0; m_beats = 0; m_ovf = 1'b0;
      end else begin
         if (st == READ_DATA1 && r && m_rdys < 63) m_rdys++;
         if (dv) begin
            if (old == 1) begin
               if (m_beats < NSTRIPS) m_strip[m_beats] = d;
               m_beats++;
               if (m_beats == m_nstr + 1) m_phase = 2;
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (old == 2 && ack) m_phase = 0;
      end
      check_all(ctx);
   endtask

   function automatic logic [WID-1:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [WID-1:0] beat [8];
      logic [WID-1:0] dead;
      for (int i = 0; i < 8; i++) beat[i] = rnd();
      dead = {32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};

      // Reset
      rst = 1'b1;
      step("reset", READ_DATA1, 1'b1, 5, 1'b1, rnd(), 1'b1);
      step("reset2", PRESET2, 1'b0, 3, 1'b0, '0, 1'b0);
      rst = 1'b0;

      // Stray beat while idle
      step("idle_stray", ST_IDLE, 1'b0, 0, 1'b1, rnd(), 1'b0);

      // Basic 4-strip burst with a beat dropped in the PRESET2 cycle
      step("b_preset", PRESET2, 1'b0, 3, 1'b1, rnd(), 1'b0);
      step("b_r0", READ_DATA1, 1'b1, 0, 1'b0, '0, 1'b0);
      step("b_r1", READ_DATA1, 1'b1, 0, 1'b1, beat[0], 1'b0);
      step("b_r2", READ_DATA1, 1'b1, 0, 1'b1, beat[1], 1'b0);
      step("b_r3", READ_DATA1, 1'b1, 0, 1'b1, beat[2], 1'b0);
      step("b_r4", READ_DATA1, 1'b1, 0, 1'b1, beat[3], 1'b0);
      step("b_hold", READ_DATA1, 1'b1, 0, 1'b0, '0, 1'b0);
      step("b_ack", ST_IDLE, 1'b0, 0, 1'b0, '0, 1'b1);
      step("b_idle", ST_IDLE, 1'b0, 0, 1'b0, '0, 1'b1);

      // rdy saturation at num_strips=1
      step("s_preset", PRESET2, 1'b0, 1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 5; i++) step("s_rdy", READ_DATA1, 1'b1, 9, 1'b0, '0, 1'b0);

      // Single strip
      step("one_preset", PRESET2, 1'b0, 0, 1'b0, '0, 1'b0);
      step("one_beat", READ_DATA0, 1'b0, 0, 1'b1, dead, 1'b0);
      step("one_hold", READ_DATA0, 1'b0, 0, 1'b0, '0, 1'b0);

      // Stray beat while holding, then PRESET2 clears overflow
      step("st_beat", READ_DATA2, 1'b0, 0, 1'b1, rnd(), 1'b0);
      step("st_hold", READ_DATA2, 1'b0, 0, 1'b0, '0, 1'b0);

      // Abort: PRESET2 with line_ack while holding
      step("ab_preset", PRESET2, 1'b0, 2, 1'b0, '0, 1'b1);
      step("ab_after", ST_IDLE, 1'b0, 2, 1'b0, '0, 1'b1);

      // Oversized burst: 6 beats, only 4 stored
      step("ov_preset", PRESET2, 1'b0, 5, 1'b0, '0, 1'b0);
      for (int i = 0; i < 6; i++) step("ov_beat", READ_DATA1, 1'b1, 0, 1'b1, beat[i+2], 1'b0);
      step("ov_hold", READ_DATA1, 1'b1, 0, 1'b0, '0, 1'b0);
      step("ov_ack", ST_IDLE, 1'b0, 0, 1'b1, rnd(), 1'b1);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         mpmc10_state_t st;
         int sel;
         sel = int'($urandom_range(0, 19));
         st = (sel == 0) ? PRESET2 : (sel < 14) ? READ_DATA1 : READ_DATA2;
         step("rand", st, 1'($urandom), int'($urandom_range(0, 6)),
              ($urandom_range(0, 2) != 0), rnd(), ($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
